escalonador_round_robin: RTL and testbench

- Round-robin process scheduler for the multiprogrammed processor. Replaces the fixed quantum counter.
- Tracks per-process state (empty/ready/blocked/finished) and saved PCs, and counts the quantum in retired instructions.
- When the running process expires, blocks on IO or terminates, it selects the next ready process and requests a context switch with a req/ack handshake toward the PC logic.

---
 rtl/escalonador_round_robin.sv | 168 ++++++++++++++++
 tb/tb_escalonador_round_robin.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/escalonador_round_robin.sv
// Round-robin process scheduler: per-slot state/PC table, instruction-counted
// quantum, and a req/ack context-switch handshake toward the PC logic.
module escalonador_round_robin #(
  parameter  int NUM_PROC = 8,
  parameter  int QUANTUM  = 16,
  parameter  int PC_W     = 32,
  localparam int ID_W     = $clog2(NUM_PROC),
  localparam int QW       = $clog2(QUANTUM) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            instr_retired,
  input  logic [PC_W-1:0] pc_retorno,
  input  logic            proc_create,
  input  logic [ID_W-1:0] proc_create_id,
  input  logic [PC_W-1:0] proc_create_pc,
  input  logic            instr_io,
  input  logic            io_done,
  input  logic [ID_W-1:0] io_done_id,
  input  logic            fim_processo,
  input  logic            troca_ack,
  output logic            troca_contexto,
  output logic [ID_W-1:0] processo_atual,
  output logic [PC_W-1:0] pc_restaurar,
  output logic            ocioso,
  output logic            todos_fim,
  output logic [QW-1:0]   quantum_restante
);

  typedef enum logic [2:0] {ST_IDLE, ST_SELECT, ST_SWITCH, ST_RUN, ST_WAIT_IO} state_t;
  typedef enum logic [1:0] {SLOT_EMPTY, SLOT_READY, SLOT_BLOCKED, SLOT_FINISHED} slot_t;

  state_t          state_q, state_d;
  slot_t           slot_q   [NUM_PROC];
  slot_t           slot_d   [NUM_PROC];
  logic [PC_W-1:0] pc_tab_q [NUM_PROC];
  logic [PC_W-1:0] pc_tab_d [NUM_PROC];
  logic [ID_W-1:0] atual_q, atual_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            todos_q, todos_d;
  logic [QW-1:0]   quantum_q, quantum_d;

  logic            create_ok, io_ok, in_run, expire, run_exit;
  logic            sel_found, any_blocked, any_finished;
  logic [ID_W-1:0] sel_id, cand;

  assign create_ok = proc_create &&
                     (slot_q[proc_create_id] == SLOT_EMPTY ||
                      slot_q[proc_create_id] == SLOT_FINISHED);
  assign io_ok     = io_done && (slot_q[io_done_id] == SLOT_BLOCKED);
  assign in_run    = (state_q == ST_RUN);
  assign expire    = in_run && instr_retired && (quantum_q == QW'(1));
  assign run_exit  = in_run && (fim_processo || instr_io || expire);

  // Search order starts one past the current process and ends on it.
  always_comb begin
    sel_found    = 1'b0;
    sel_id       = '0;
    cand         = '0;
    any_blocked  = 1'b0;
    any_finished = 1'b0;
    for (int unsigned i = 1; i <= NUM_PROC; i++) begin
      cand = atual_q + ID_W'(i);
      if (!sel_found && slot_q[cand] == SLOT_READY) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
    for (int unsigned i = 0; i < NUM_PROC; i++) begin
      if (slot_q[i] == SLOT_BLOCKED)  any_blocked  = 1'b1;
      if (slot_q[i] == SLOT_FINISHED) any_finished = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (enable) state_d = ST_SELECT;
      ST_SELECT: begin
        if (sel_found)        state_d = ST_SWITCH;
        else if (any_blocked) state_d = ST_WAIT_IO;
        else                  state_d = ST_IDLE;
      end
      ST_SWITCH:  if (troca_ack) state_d = ST_RUN;
      ST_RUN:     if (run_exit)  state_d = ST_SELECT;
      // sel_found also catches a slot readied during the SELECT cycle itself.
      ST_WAIT_IO: if (create_ok || io_ok || sel_found) state_d = ST_SELECT;
      default:    state_d = ST_IDLE;
    endcase
    if (!enable) state_d = ST_IDLE;
  end

  always_comb begin
    troca_contexto   = (state_q == ST_SWITCH);
    ocioso           = (state_q == ST_WAIT_IO);
    processo_atual   = atual_q;
    pc_restaurar     = pc_q;
    todos_fim        = todos_q;
    quantum_restante = quantum_q;
  end

  // Slot writes never collide: each update is gated on a distinct current state.
  always_comb begin
    slot_d   = slot_q;
    pc_tab_d = pc_tab_q;
    if (create_ok) begin
      slot_d[proc_create_id]   = SLOT_READY;
      pc_tab_d[proc_create_id] = proc_create_pc;
    end
    if (io_ok) slot_d[io_done_id] = SLOT_READY;
    if (in_run) begin
      if (fim_processo) begin
        slot_d[atual_q] = SLOT_FINISHED;
      end else if (instr_io) begin
        slot_d[atual_q]   = SLOT_BLOCKED;
        pc_tab_d[atual_q] = pc_retorno;
      end else if (expire) begin
        pc_tab_d[atual_q] = pc_retorno;
      end
    end
  end

  always_comb begin
    atual_d   = atual_q;
    pc_d      = pc_q;
    todos_d   = todos_q;
    quantum_d = quantum_q;
    if (state_q == ST_SELECT && sel_found) begin
      atual_d = sel_id;
      pc_d    = pc_tab_q[sel_id];
    end
    if (create_ok)
      todos_d = 1'b0;
    else if (state_q == ST_SELECT && !sel_found && !any_blocked && any_finished)
      todos_d = 1'b1;
    if (state_q == ST_SWITCH && troca_ack)
      quantum_d = QW'(QUANTUM);
    else if (in_run && instr_retired)
      quantum_d = quantum_q - QW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PROC; i++) begin
        slot_q[i]   <= SLOT_EMPTY;
        pc_tab_q[i] <= '0;
      end
      atual_q   <= '0;
      pc_q      <= '0;
      todos_q   <= 1'b0;
      quantum_q <= QW'(QUANTUM);
    end else begin
      slot_q    <= slot_d;
      pc_tab_q  <= pc_tab_d;
      atual_q   <= atual_d;
      pc_q      <= pc_d;
      todos_q   <= todos_d;
      quantum_q <= quantum_d;
    end
  end

endmodule

// File: tb/tb_escalonador_round_robin.sv
// Directed scenario bench for escalonador_round_robin (NUM_PROC=8, QUANTUM=16, PC_W=32).
module tb_escalonador_round_robin;

  logic        clock = 1'b0;
  logic        reset, enable, instr_retired, proc_create, instr_io;
  logic        io_done, fim_processo, troca_ack;
  logic [31:0] pc_retorno, proc_create_pc;
  logic [2:0]  proc_create_id, io_done_id;
  logic        troca_contexto, ocioso, todos_fim;
  logic [2:0]  processo_atual;
  logic [31:0] pc_restaurar;
  logic [4:0]  quantum_restante;

  int checks = 0;
  int failures = 0;

  escalonador_round_robin #(.NUM_PROC(8), .QUANTUM(16), .PC_W(32)) dut (
    .clock(clock), .reset(reset), .enable(enable), .instr_retired(instr_retired),
    .pc_retorno(pc_retorno), .proc_create(proc_create), .proc_create_id(proc_create_id),
    .proc_create_pc(proc_create_pc), .instr_io(instr_io), .io_done(io_done),
    .io_done_id(io_done_id), .fim_processo(fim_processo), .troca_ack(troca_ack),
    .troca_contexto(troca_contexto), .processo_atual(processo_atual),
    .pc_restaurar(pc_restaurar), .ocioso(ocioso), .todos_fim(todos_fim),
    .quantum_restante(quantum_restante)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic create(input logic [2:0] id, input logic [31:0] pc);
    proc_create = 1'b1; proc_create_id = id; proc_create_pc = pc;
    cyc(1);
    proc_create = 1'b0;
  endtask

  task automatic ack_switch();
    troca_ack = 1'b1;
    cyc(1);
    troca_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(2);
    checks++; if (troca_contexto !== 1'b0) begin failures++; $display("FAIL reset_troca got=%0h exp=0", troca_contexto); end
    checks++; if (processo_atual !== 3'd0) begin failures++; $display("FAIL reset_atual got=%0h exp=0", processo_atual); end
    checks++; if (pc_restaurar !== 32'd0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc_restaurar); end
    checks++; if (ocioso !== 1'b0) begin failures++; $display("FAIL reset_ocioso got=%0h exp=0", ocioso); end
    checks++; if (todos_fim !== 1'b0) begin failures++; $display("FAIL reset_todos got=%0h exp=0", todos_fim); end
    checks++; if (quantum_restante !== 5'd16) begin failures++; $display("FAIL reset_quantum got=%0d exp=16", quantum_restante); end
    reset = 1'b0;
  endtask

  task automatic test_rr_expiry();
    create(3'd0, 32'd100);
    create(3'd1, 32'd200);
    enable = 1'b1;
    cyc(1);
    checks++; if (troca_contexto !== 1'b0) begin failures++; $display("FAIL rr_select_troca got=%0h exp=0", troca_contexto); end
    cyc(1);
    checks++; if (troca_contexto !== 1'b1) begin failures++; $display("FAIL rr_first_troca got=%0h exp=1", troca_contexto); end
    checks++; if (processo_atual !== 3'd1) begin failures++; $display("FAIL rr_first_id got=%0h exp=1", processo_atual); end
    checks++; if (pc_restaurar !== 32'd200) begin failures++; $display("FAIL rr_first_pc got=%0d exp=200", pc_restaurar); end
    ack_switch();
    checks++; if (troca_contexto !== 1'b0) begin failures++; $display("FAIL rr_ack_drop got=%0h exp=0", troca_contexto); end
    checks++; if (quantum_restante !== 5'd16) begin failures++; $display("FAIL rr_quantum_load got=%0d exp=16", quantum_restante); end
    instr_retired = 1'b1; pc_retorno = 32'd250;
    cyc(15);
    checks++; if (quantum_restante !== 5'd1) begin failures++; $display("FAIL rr_quantum_count got=%0d exp=1", quantum_restante); end
    checks++; if (troca_contexto !== 1'b0) begin failures++; $display("FAIL rr_no_early_switch got=%0h exp=0", troca_contexto); end
    cyc(1);
    instr_retired = 1'b0;
    cyc(1);
    checks++; if (troca_contexto !== 1'b1) begin failures++; $display("FAIL rr_exp_troca got=%0h exp=1", troca_contexto); end
    checks++; if (processo_atual !== 3'd0) begin failures++; $display("FAIL rr_exp_id got=%0h exp=0", processo_atual); end
    checks++; if (pc_restaurar !== 32'd100) begin failures++; $display("FAIL rr_exp_pc got=%0d exp=100", pc_restaurar); end
    ack_switch();
    checks++; if (quantum_restante !== 5'd16) begin failures++; $display("FAIL rr_quantum_reload got=%0d exp=16", quantum_restante); end
  endtask

  task automatic test_io_block();
    pc_retorno = 32'd140; instr_io = 1'b1;
    cyc(1);
    instr_io = 1'b0;
    checks++; if (troca_contexto !== 1'b0) begin failures++; $display("FAIL io_select_troca got=%0h exp=0", troca_contexto); end
    cyc(1);
    checks++; if (troca_contexto !== 1'b1) begin failures++; $display("FAIL io_troca got=%0h exp=1", troca_contexto); end
    checks++; if (processo_atual !== 3'd1) begin failures++; $display("FAIL io_next_id got=%0h exp=1", processo_atual); end
    checks++; if (pc_restaurar !== 32'd250) begin failures++; $display("FAIL io_saved_pc1 got=%0d exp=250", pc_restaurar); end
    ack_switch();
    io_done = 1'b1; io_done_id = 3'd0;
    cyc(1);
    io_done = 1'b0; fim_processo = 1'b1;
    cyc(1);
    fim_processo = 1'b0;
    cyc(1);
    checks++; if (processo_atual !== 3'd0) begin failures++; $display("FAIL io_resume_id got=%0h exp=0", processo_atual); end
    checks++; if (pc_restaurar !== 32'd140) begin failures++; $display("FAIL io_saved_pc0 got=%0d exp=140", pc_restaurar); end
    ack_switch();
  endtask

  task automatic test_fim_priority();
    fim_processo = 1'b1; instr_io = 1'b1; pc_retorno = 32'd999;
    cyc(1);
    fim_processo = 1'b0; instr_io = 1'b0;
    cyc(1);
    checks++; if (todos_fim !== 1'b1) begin failures++; $display("FAIL fim_todos got=%0h exp=1", todos_fim); end
    checks++; if (troca_contexto !== 1'b0) begin failures++; $display("FAIL fim_troca got=%0h exp=0", troca_contexto); end
    enable = 1'b0;
    cyc(1);
    checks++; if (ocioso !== 1'b0) begin failures++; $display("FAIL fim_not_blocked got=%0h exp=0", ocioso); end
    checks++; if (todos_fim !== 1'b1) begin failures++; $display("FAIL fim_todos_hold got=%0h exp=1", todos_fim); end
    create(3'd2, 32'd300);
    checks++; if (todos_fim !== 1'b0) begin failures++; $display("FAIL fim_create_clear got=%0h exp=0", todos_fim); end
  endtask

  task automatic test_wait_io();
    enable = 1'b1;
    cyc(2);
    checks++; if (processo_atual !== 3'd2) begin failures++; $display("FAIL wio_id got=%0h exp=2", processo_atual); end
    checks++; if (pc_restaurar !== 32'd300) begin failures++; $display("FAIL wio_pc got=%0d exp=300", pc_restaurar); end
    ack_switch();
    pc_retorno = 32'd340; instr_io = 1'b1;
    cyc(1);
    instr_io = 1'b0;
    cyc(1);
    checks++; if (ocioso !== 1'b1) begin failures++; $display("FAIL wio_ocioso got=%0h exp=1", ocioso); end
    cyc(2);
    checks++; if (ocioso !== 1'b1) begin failures++; $display("FAIL wio_ocioso_hold got=%0h exp=1", ocioso); end
    io_done = 1'b1; io_done_id = 3'd2;
    cyc(1);
    io_done = 1'b0;
    checks++; if (ocioso !== 1'b0) begin failures++; $display("FAIL wio_ocioso_drop got=%0h exp=0", ocioso); end
    cyc(1);
    checks++; if (troca_contexto !== 1'b1) begin failures++; $display("FAIL wio_troca got=%0h exp=1", troca_contexto); end
    checks++; if (processo_atual !== 3'd2) begin failures++; $display("FAIL wio_resume_id got=%0h exp=2", processo_atual); end
    checks++; if (pc_restaurar !== 32'd340) begin failures++; $display("FAIL wio_resume_pc got=%0d exp=340", pc_restaurar); end
    ack_switch();
  endtask

  task automatic test_self_reselect();
    instr_retired = 1'b1; pc_retorno = 32'd400;
    cyc(15);
    io_done = 1'b1; io_done_id = 3'd0;
    cyc(1);
    instr_retired = 1'b0; io_done = 1'b0;
    checks++; if (troca_contexto !== 1'b0) begin failures++; $display("FAIL self_select_troca got=%0h exp=0", troca_contexto); end
    cyc(1);
    checks++; if (troca_contexto !== 1'b1) begin failures++; $display("FAIL self_troca got=%0h exp=1", troca_contexto); end
    checks++; if (processo_atual !== 3'd2) begin failures++; $display("FAIL self_id got=%0h exp=2", processo_atual); end
    checks++; if (pc_restaurar !== 32'd400) begin failures++; $display("FAIL self_pc got=%0d exp=400", pc_restaurar); end
    ack_switch();
    checks++; if (quantum_restante !== 5'd16) begin failures++; $display("FAIL self_quantum got=%0d exp=16", quantum_restante); end
  endtask

  task automatic test_ack_hold_reset();
    create(3'd3, 32'd500);
    fim_processo = 1'b1;
    cyc(1);
    fim_processo = 1'b0;
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      checks++; if (troca_contexto !== 1'b1) begin failures++; $display("FAIL hold_troca[%0d] got=%0h exp=1", i, troca_contexto); end
      checks++; if (pc_restaurar !== 32'd500) begin failures++; $display("FAIL hold_pc[%0d] got=%0d exp=500", i, pc_restaurar); end
      cyc(1);
    end
    reset = 1'b1;
    cyc(1);
    checks++; if (troca_contexto !== 1'b0) begin failures++; $display("FAIL mreset_troca got=%0h exp=0", troca_contexto); end
    checks++; if (processo_atual !== 3'd0) begin failures++; $display("FAIL mreset_atual got=%0h exp=0", processo_atual); end
    checks++; if (pc_restaurar !== 32'd0) begin failures++; $display("FAIL mreset_pc got=%0h exp=0", pc_restaurar); end
    checks++; if (ocioso !== 1'b0) begin failures++; $display("FAIL mreset_ocioso got=%0h exp=0", ocioso); end
    checks++; if (todos_fim !== 1'b0) begin failures++; $display("FAIL mreset_todos got=%0h exp=0", todos_fim); end
    checks++; if (quantum_restante !== 5'd16) begin failures++; $display("FAIL mreset_quantum got=%0d exp=16", quantum_restante); end
    reset = 1'b0;
  endtask

  task automatic test_enable_drop();
    enable = 1'b0;
    create(3'd5, 32'h55);
    enable = 1'b1;
    cyc(2);
    checks++; if (troca_contexto !== 1'b1) begin failures++; $display("FAIL en_troca got=%0h exp=1", troca_contexto); end
    checks++; if (processo_atual !== 3'd5) begin failures++; $display("FAIL en_id got=%0h exp=5", processo_atual); end
    enable = 1'b0;
    cyc(1);
    checks++; if (troca_contexto !== 1'b0) begin failures++; $display("FAIL en_drop got=%0h exp=0", troca_contexto); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; instr_retired = 1'b0; pc_retorno = '0;
    proc_create = 1'b0; proc_create_id = '0; proc_create_pc = '0;
    instr_io = 1'b0; io_done = 1'b0; io_done_id = '0; fim_processo = 1'b0; troca_ack = 1'b0;
    test_reset();
    test_rr_expiry();
    test_io_block();
    test_fim_priority();
    test_wait_io();
    test_self_reselect();
    test_ack_hold_reset();
    test_enable_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
